// File: rtl/mp1000_pkg.sv
// Shared MP1000 core constants: ioctl target indices, default fill byte and
// the upload responder's session states.
package mp1000_pkg;

    localparam logic [7:0] IDX_ROM_DOWNLOAD  = 8'h00;
    localparam logic [7:0] IDX_CART_DOWNLOAD = 8'h01;
    localparam logic [7:0] IDX_RAM_UPLOAD    = 8'h02;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        UPL_IDLE,
        UPL_READY,
        UPL_REQ,
        UPL_LAT
    } upl_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mp1000_ioctl_uploader_if.sv
// Request/grant read port into the shared MP1000 work RAM arbiter.
interface mp1000_ioctl_uploader_if #(
    parameter int ADDR_W = 16
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [7:0]        mem_q;

    modport master (output mem_req, mem_addr, input  mem_gnt, mem_q);
    modport slave  (input  mem_req, mem_addr, output mem_gnt, mem_q);

endinterface

// File: rtl/mp1000_ioctl_uploader.sv
// Host ioctl upload responder: fetches requested bytes from work RAM through
// the arbitrated read port, stalling the host with ioctl_wait meanwhile.
module mp1000_ioctl_uploader
    import mp1000_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter int         REGION_SIZE  = 1024,
    parameter int         RD_LAT       = 1,
    parameter logic [7:0] UPLOAD_INDEX = IDX_RAM_UPLOAD,
    parameter logic [7:0] FILL         = FILL_DEFAULT
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic                           ioctl_upload,
    input  logic [7:0]                     ioctl_index,
    input  logic                           ioctl_rd,
    input  logic [24:0]                    ioctl_addr,
    output logic [7:0]                     ioctl_din,
    output logic                           ioctl_wait,
    mp1000_ioctl_uploader_if.master        mem,
    output logic                           upload_active,
    output logic [15:0]                    upload_bytes,
    output logic [7:0]                     upload_xor
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    upl_state_e        state_q, state_d;
    logic              upload_q;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;
    logic              active_q, active_d;
    logic [15:0]       bytes_q, bytes_d;
    logic [7:0]        xor_q, xor_d;

    logic upload_rise;
    logic in_range;

    assign upload_rise = ioctl_upload && !upload_q;
    // Full 25-bit compare: high address bits never alias into the region.
    assign in_range    = {7'd0, ioctl_addr} < 32'(REGION_SIZE);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first so
        // no path through the case leaves a signal unassigned (no latches).
        state_d  = state_q;
        din_d    = din_q;
        wait_d   = wait_q;
        req_d    = req_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        active_d = active_q;
        bytes_d  = bytes_q;
        xor_d    = xor_q;

        if (!ioctl_upload) begin
            // Session closed: drop any fetch in flight, keep counters and data.
            state_d  = UPL_IDLE;
            req_d    = 1'b0;
            wait_d   = 1'b0;
            active_d = 1'b0;
        end else begin
            unique case (state_q)
                UPL_IDLE: begin
                    if (upload_rise) begin
                        if (ioctl_index == UPLOAD_INDEX) begin
                            state_d  = UPL_READY;
                            active_d = 1'b1;
                            bytes_d  = '0;
                            xor_d    = '0;
                        end
                    end else if (ioctl_rd) begin
                        din_d = FILL;
                    end
                end
                UPL_READY: begin
                    if (ioctl_rd) begin
                        if (in_range) begin
                            state_d = UPL_REQ;
                            req_d   = 1'b1;
                            wait_d  = 1'b1;
                            addr_d  = ioctl_addr[ADDR_W-1:0];
                        end else begin
                            din_d   = FILL;
                            bytes_d = sat_inc16(bytes_q);
                            xor_d   = xor_q ^ FILL;
                        end
                    end
                end
                UPL_REQ: begin
                    if (mem.mem_gnt) begin
                        state_d = UPL_LAT;
                        req_d   = 1'b0;
                        lat_d   = LAT_INIT;
                    end
                end
                UPL_LAT: begin
                    if (lat_q == 2'd0) begin
                        state_d = UPL_READY;
                        din_d   = mem.mem_q;
                        wait_d  = 1'b0;
                        bytes_d = sat_inc16(bytes_q);
                        xor_d   = xor_q ^ mem.mem_q;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                default: state_d = UPL_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= UPL_IDLE;
            upload_q <= 1'b0;
            din_q    <= FILL;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            lat_q    <= '0;
            active_q <= 1'b0;
            bytes_q  <= '0;
            xor_q    <= '0;
        end else begin
            state_q  <= state_d;
            upload_q <= ioctl_upload;
            din_q    <= din_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            active_q <= active_d;
            bytes_q  <= bytes_d;
            xor_q    <= xor_d;
        end
    end

    assign ioctl_din     = din_q;
    assign ioctl_wait    = wait_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;
    assign upload_active = active_q;
    assign upload_bytes  = bytes_q;
    assign upload_xor    = xor_q;

endmodule

// File: tb/tb_mp1000_ioctl_uploader.sv
// Bench for mp1000_ioctl_uploader: two instances (RD_LAT 1 and 2) share the
// host stimulus; each has its own arbiter/RAM model with programmable grant delay.
module tb_mp1000_ioctl_uploader;
    import mp1000_pkg::*;

    localparam int ADDR_W = 16;
    localparam int REGION = 1024;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;

    always #5 clk_sys = ~clk_sys;

    logic [1:0][7:0]        din_o;
    logic [1:0]             wait_o, active_o, req_o;
    logic [1:0][15:0]       bytes_o;
    logic [1:0][7:0]        xor_o;
    logic [1:0][ADDR_W-1:0] addr_o;
    logic [1:0]             gnt_i;
    logic [1:0][7:0]        q_i;

    mp1000_ioctl_uploader_if #(.ADDR_W(ADDR_W)) mif [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign req_o[g]         = mif[g].mem_req;
        assign addr_o[g]        = mif[g].mem_addr;
        assign mif[g].mem_gnt   = gnt_i[g];
        assign mif[g].mem_q     = q_i[g];

        mp1000_ioctl_uploader #(
            .ADDR_W(ADDR_W), .REGION_SIZE(REGION), .RD_LAT(g + 1),
            .UPLOAD_INDEX(8'h02), .FILL(8'hFF)
        ) u_dut (
            .clk_sys(clk_sys), .reset_n(reset_n),
            .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
            .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
            .ioctl_din(din_o[g]), .ioctl_wait(wait_o[g]),
            .mem(mif[g]),
            .upload_active(active_o[g]), .upload_bytes(bytes_o[g]),
            .upload_xor(xor_o[g])
        );
    end

    // Arbiter + RAM model: grant after grant_delay requesting cycles, data
    // valid RD_LAT cycles after the grant cycle, noise otherwise.
    logic [7:0]       ram [REGION];
    int               grant_delay = 0;
    logic             force_gnt = 1'b0;
    int               req_cyc [2];
    logic [3:0]       pv [2];
    logic [3:0][15:0] pa [2];
    logic [7:0]       noise;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gnt_i[i] = force_gnt || (req_o[i] && req_cyc[i] == grant_delay);
            q_i[i]   = pv[i][i] ? ram[pa[i][i][9:0]] : noise;
        end
    end

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            noise <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                pv[i]      <= '0;
                pa[i]      <= '0;
                req_cyc[i] <= 0;
            end
        end else begin
            noise <= 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                pv[i] <= {pv[i][2:0], gnt_i[i]};
                pa[i] <= {pa[i][2:0], addr_o[i]};
                req_cyc[i] <= (req_o[i] && !gnt_i[i]) ? req_cyc[i] + 1 : 0;
            end
        end
    end

    // Request monitor: counts mem_req cycles and address deviations.
    int          req_seen [2] = '{0, 0};
    int          addr_bad [2] = '{0, 0};
    logic [15:0] exp_addr = '0;

    always @(negedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (req_o[i]) begin
                req_seen[i] <= req_seen[i] + 1;
                if (addr_o[i] != exp_addr) addr_bad[i] <= addr_bad[i] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference model of the session counters.
    logic [15:0] m_bytes = '0;
    logic [7:0]  m_xor   = '0;

    task automatic start_session(input logic [7:0] idx, input logic matching);
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        next_cycle();
        if (matching) begin
            m_bytes = '0;
            m_xor   = '0;
        end
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("start%0h/dut%0d/active", idx, i), 32'(active_o[i]), 32'(matching));
            check($sformatf("start%0h/dut%0d/bytes", idx, i), 32'(bytes_o[i]), 32'(m_bytes));
            check($sformatf("start%0h/dut%0d/xor", idx, i), 32'(xor_o[i]), 32'(m_xor));
        end
        next_cycle();
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        next_cycle();
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("end/dut%0d/active", i), 32'(active_o[i]), 32'd0);
            check($sformatf("end/dut%0d/req", i), 32'(req_o[i]), 32'd0);
        end
        next_cycle();
    endtask

    // One host read; latency = first cycle after the strobe with wait low.
    task automatic do_read(input logic [24:0] addr, input int delay, input logic [7:0] exp_byte,
                           input int lat1, input int lat2, input string tag);
        int         lat [2];
        int         exp_lat [2];
        logic [7:0] got [2];
        logic [15:0] gb [2];
        logic [7:0] gx [2];
        int         base_req [2];
        int         base_bad [2];
        logic       inr;
        inr = ({7'd0, addr} < 32'(REGION));
        exp_lat = '{lat1, lat2};
        lat = '{-1, -1};
        for (int i = 0; i < 2; i++) begin
            base_req[i] = req_seen[i];
            base_bad[i] = addr_bad[i];
            got[i] = 8'h00; gb[i] = '0; gx[i] = '0;
        end
        grant_delay = delay;
        exp_addr    = addr[15:0];
        ioctl_addr  = addr;
        ioctl_rd    = 1'b1;
        next_cycle();
        ioctl_rd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                if (lat[i] < 0 && !wait_o[i]) begin
                    lat[i] = k;
                    got[i] = din_o[i];
                    gb[i]  = bytes_o[i];
                    gx[i]  = xor_o[i];
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0) break;
            next_cycle();
        end
        next_cycle();
        if (m_bytes != 16'hFFFF) m_bytes = m_bytes + 16'd1;
        m_xor = m_xor ^ exp_byte;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s/dut%0d/latency", tag, i), 32'(lat[i]), 32'(exp_lat[i]));
            check($sformatf("%s/dut%0d/din", tag, i), 32'(got[i]), 32'(exp_byte));
            check($sformatf("%s/dut%0d/bytes", tag, i), 32'(gb[i]), 32'(m_bytes));
            check($sformatf("%s/dut%0d/xor", tag, i), 32'(gx[i]), 32'(m_xor));
            check($sformatf("%s/dut%0d/req_cycles", tag, i), 32'(req_seen[i] - base_req[i]),
                  inr ? 32'(delay + 1) : 32'd0);
            check($sformatf("%s/dut%0d/addr_held", tag, i), 32'(addr_bad[i] - base_bad[i]), 32'd0);
        end
    endtask

    typedef struct {
        logic [24:0] addr;
        int          delay;
        logic [7:0]  exp_byte;
        int          lat1;
        int          lat2;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        logic [7:0]  din_prev [2];
        logic [24:0] ra;
        int          rd_delay;
        int          sel;
        logic        inr;
        logic [7:0]  rb;

        for (int a = 0; a < REGION; a++) ram[a] = 8'($urandom);
        ram[10'h010] = 8'h5A;
        ram[10'h3FF] = 8'hC3;
        ram[10'h000] = 8'h3C;
        ram[10'h020] = 8'h77;

        // in-range latency = 2 + grant delay + RD_LAT; out of range = 1
        vecs[0] = '{25'h0000010, 0, 8'h5A, 3, 4};
        vecs[1] = '{25'h00003FF, 5, 8'hC3, 8, 9};
        vecs[2] = '{25'h0000400, 0, 8'hFF, 1, 1};
        vecs[3] = '{25'h1000400, 0, 8'hFF, 1, 1};
        vecs[4] = '{25'h0000000, 2, 8'h3C, 5, 6};
        vecs[5] = '{25'h00003FF, 0, 8'hC3, 3, 4};

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset/dut%0d/din", i), 32'(din_o[i]), 32'hFF);
            check($sformatf("reset/dut%0d/wait", i), 32'(wait_o[i]), 32'd0);
            check($sformatf("reset/dut%0d/req", i), 32'(req_o[i]), 32'd0);
            check($sformatf("reset/dut%0d/active", i), 32'(active_o[i]), 32'd0);
            check($sformatf("reset/dut%0d/bytes", i), 32'(bytes_o[i]), 32'd0);
            check($sformatf("reset/dut%0d/xor", i), 32'(xor_o[i]), 32'd0);
        end
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        // Strobe coinciding with the session rising edge must be ignored.
        ioctl_index  = 8'h02;
        ioctl_upload = 1'b1;
        ioctl_addr   = 25'h010;
        ioctl_rd     = 1'b1;
        next_cycle();
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rise_rd/dut%0d/active", i), 32'(active_o[i]), 32'd1);
            check($sformatf("rise_rd/dut%0d/req", i), 32'(req_o[i]), 32'd0);
            check($sformatf("rise_rd/dut%0d/wait", i), 32'(wait_o[i]), 32'd0);
            check($sformatf("rise_rd/dut%0d/bytes", i), 32'(bytes_o[i]), 32'd0);
        end
        next_cycle();

        for (int v = 0; v < 6; v++)
            do_read(vecs[v].addr, vecs[v].delay, vecs[v].exp_byte, vecs[v].lat1, vecs[v].lat2,
                    $sformatf("vec%0d", v));

        // Randomized reads; index changes mid-session must not matter.
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       ra = 25'($urandom_range(0, REGION - 1));
            else if (sel == 7) ra = 25'(REGION + $urandom_range(0, 3000));
            else if (sel == 8) ra = 25'h1000000 | 25'($urandom_range(0, REGION - 1));
            else               ra = 25'h1FFFFFF;
            rd_delay = int'($urandom_range(0, 4));
            if (n == 10) ioctl_index = 8'h05;
            inr = ({7'd0, ra} < 32'(REGION));
            rb  = inr ? ram[ra[9:0]] : 8'hFF;
            do_read(ra, rd_delay, rb, inr ? 3 + rd_delay : 1, inr ? 4 + rd_delay : 1,
                    $sformatf("rnd%0d", n));
        end

        // Session dropped while the fetch waits for a grant.
        for (int i = 0; i < 2; i++) din_prev[i] = din_o[i];
        grant_delay = 1000;
        exp_addr    = 16'h0020;
        ioctl_addr  = 25'h020;
        ioctl_rd    = 1'b1;
        next_cycle();
        ioctl_rd = 1'b0;
        next_cycle();
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("drop/dut%0d/req_before", i), 32'(req_o[i]), 32'd1);
            check($sformatf("drop/dut%0d/wait_before", i), 32'(wait_o[i]), 32'd1);
        end
        next_cycle();
        ioctl_upload = 1'b0;
        next_cycle();
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("drop/dut%0d/req", i), 32'(req_o[i]), 32'd0);
            check($sformatf("drop/dut%0d/wait", i), 32'(wait_o[i]), 32'd0);
            check($sformatf("drop/dut%0d/active", i), 32'(active_o[i]), 32'd0);
            check($sformatf("drop/dut%0d/din", i), 32'(din_o[i]), 32'(din_prev[i]));
        end
        next_cycle();
        force_gnt = 1'b1;
        next_cycle();
        force_gnt = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("late_gnt/dut%0d/din", i), 32'(din_o[i]), 32'(din_prev[i]));
            check($sformatf("late_gnt/dut%0d/wait", i), 32'(wait_o[i]), 32'd0);
            check($sformatf("late_gnt/dut%0d/bytes", i), 32'(bytes_o[i]), 32'(m_bytes));
            check($sformatf("late_gnt/dut%0d/xor", i), 32'(xor_o[i]), 32'(m_xor));
        end
        next_cycle();
        grant_delay = 0;

        // New session clears counters; then a non-matching session.
        start_session(8'h02, 1'b1);
        do_read(vecs[0].addr, 0, 8'h5A, 3, 4, "sess2");
        end_session();
        start_session(8'h01, 1'b0);
        begin
            int base_req [2];
            for (int i = 0; i < 2; i++) base_req[i] = req_seen[i];
            ioctl_addr = 25'h000;
            ioctl_rd   = 1'b1;
            next_cycle();
            ioctl_rd = 1'b0;
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("nomatch/dut%0d/din", i), 32'(din_o[i]), 32'hFF);
                check($sformatf("nomatch/dut%0d/wait", i), 32'(wait_o[i]), 32'd0);
                check($sformatf("nomatch/dut%0d/active", i), 32'(active_o[i]), 32'd0);
                check($sformatf("nomatch/dut%0d/bytes", i), 32'(bytes_o[i]), 32'(m_bytes));
                check($sformatf("nomatch/dut%0d/xor", i), 32'(xor_o[i]), 32'(m_xor));
            end
            next_cycle();
            next_cycle();
            for (int i = 0; i < 2; i++)
                check($sformatf("nomatch/dut%0d/req_cycles", i), 32'(req_seen[i] - base_req[i]), 32'd0);
        end
        end_session();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
